// File: rtl/regfile_sb.sv
// regfile_sb: NR-read / NW-write integer register file with a per-register busy scoreboard; x0 reads 0.
// Latency: rd, rbusy and rsv_grant are combinational; writes and reservations take effect at the next posedge.
// Backpressure: rsv_grant=0 refuses a busy destination (issue stalls). REGFILE_BYPASS_EN enables write-first forwarding.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NR   = 2,
    parameter int NW   = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     wa,
    input  logic [NW*XLEN-1:0]   wd,
    input  logic [NR*AW-1:0]     ra,
    output logic [NR*XLEN-1:0]   rd,
    output logic [NR-1:0]        rbusy,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_grant,
    output logic [NREG-1:0]      busy_vec
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wr_clr;
    logic            rsv_busy;

    // One-hot set of registers receiving an effective write this cycle (x0 excluded).
    always_comb begin
        wr_clr = '0;
        for (int w = 0; w < NW; w++) begin
            if (we[w] && (wa[w*AW +: AW] != '0)) begin
                wr_clr[wa[w*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int r = 0; r < NR; r++) begin
            if (ra[r*AW +: AW] != '0) begin
                rd[r*XLEN +: XLEN] = rf_q[ra[r*AW +: AW]];
                rbusy[r]           = busy_q[ra[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NW; w++) begin
                    if (we[w] && (wa[w*AW +: AW] == ra[r*AW +: AW])) begin
                        rd[r*XLEN +: XLEN] = wd[w*XLEN +: XLEN];
                        rbusy[r]           = 1'b0;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        rsv_busy = busy_q[rsv_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_clr[rsv_addr]) begin
            rsv_busy = 1'b0;
        end
`endif
        rsv_grant = reset_n & rsv_en & ((rsv_addr == '0) | ~rsv_busy);
    end

    // Ascending port order makes the highest-index writer win; the reservation set is applied last so it beats a same-cycle clear.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q & ~wr_clr;
        for (int w = 0; w < NW; w++) begin
            if (we[w] && (wa[w*AW +: AW] != '0)) begin
                rf_d[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
            end
        end
        if (rsv_grant && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        rf_d[0]   = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rf_q   <= rf_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int AW   = 5;

    logic                 clk;
    logic                 reset_n;
    logic [NW-1:0]        we;
    logic [NW*AW-1:0]     wa;
    logic [NW*XLEN-1:0]   wd;
    logic [NR*AW-1:0]     ra;
    logic [NR*XLEN-1:0]   rd;
    logic [NR-1:0]        rbusy;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic                 rsv_grant;
    logic [NREG-1:0]      busy_vec;

    logic [XLEN-1:0] m_rf   [NREG];
    logic            m_busy [NREG];
    int total = 0;
    int bad   = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_grant(rsv_grant), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int last_writer(input int a);
        int p;
        p = -1;
        for (int w = 0; w < NW; w++)
            if (we[w] && int'(wa[w*AW +: AW]) == a && a != 0) p = w;
        return p;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (last_writer(a) >= 0) return wd[last_writer(a)*XLEN +: XLEN];
`endif
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (last_writer(a) >= 0) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_grant();
        return reset_n && rsv_en && (rsv_addr == 0 || !exp_busy(int'(rsv_addr)));
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance the model by one edge using the inputs currently driven, then step the DUT.
    task automatic tick();
        logic g;
        g = exp_grant();
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_rf[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (we[w] && wa[w*AW +: AW] != 0) begin
                    m_rf[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
                    m_busy[wa[w*AW +: AW]] = 1'b0;
                end
            end
            if (g && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; ra = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < NREG; i += 2) begin
            idle();
            we[0] = 1'b1; wa[0 +: AW] = AW'(i); wd[0 +: XLEN] = XLEN'(i);
            if (i + 1 < NREG) begin
                we[1] = 1'b1; wa[AW +: AW] = AW'(i + 1); wd[XLEN +: XLEN] = XLEN'(i + 1);
            end
            rsv_en = 1'b1; rsv_addr = AW'(i + 2);
            tick();
        end
        idle();
        ra[0 +: AW] = 5'd5;
        #1;
        total++;
        if (rd[0 +: XLEN] !== 32'd5) begin
            bad++; $display("FAIL pre_reset_x5 got=%h exp=%h", rd[0 +: XLEN], 32'd5);
        end
        reset_n = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd4;
        we = 2'b11; wa = {5'd6, 5'd7}; wd = {32'h1, 32'h2};
        #1;
        total++;
        if (rsv_grant !== 1'b0) begin
            bad++; $display("FAIL grant_in_reset got=%b exp=0", rsv_grant);
        end
        tick();
        reset_n = 1'b1;
        idle();
        for (int a = 0; a < NREG; a++) begin
            ra = {AW'(NREG - 1 - a), AW'(a)};
            #1;
            total++;
            if (rd !== '0 || rbusy !== '0) begin
                bad++; $display("FAIL reset_read a=%0d got rd=%h rbusy=%b exp 0", a, rd, rbusy);
            end
        end
        total++;
        if (busy_vec !== '0) begin
            bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_same_addr_write();
        idle();
        we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h22222222, 32'h11111111};
        tick();
        idle();
        ra = {5'd5, 5'd5};
        #1;
        total++;
        if (rd !== {32'h22222222, 32'h22222222}) begin
            bad++; $display("FAIL same_addr_x5 got=%h exp=%h", rd, {32'h22222222, 32'h22222222});
        end
    endtask

    task automatic test_x0();
        idle();
        we = 2'b01; wa = '0; wd[0 +: XLEN] = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = '0;
        #1;
        total++;
        if (rsv_grant !== 1'b1) begin
            bad++; $display("FAIL x0_grant got=%b exp=1", rsv_grant);
        end
        tick();
        idle();
        ra = '0;
        #1;
        total++;
        if (rd !== '0 || rbusy !== '0 || busy_vec !== '0) begin
            bad++; $display("FAIL x0_read got rd=%h rbusy=%b vec=%h exp all 0", rd, rbusy, busy_vec);
        end
    endtask

    task automatic test_reserve();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        #1;
        total++;
        if (rsv_grant !== 1'b1) begin
            bad++; $display("FAIL rsv7_grant got=%b exp=1", rsv_grant);
        end
        tick();
        total++;
        if (busy_vec[7] !== 1'b1) begin
            bad++; $display("FAIL rsv7_busy got=%b exp=1", busy_vec[7]);
        end
        #1;
        total++;
        if (rsv_grant !== 1'b0) begin
            bad++; $display("FAIL rsv7_waw_grant got=%b exp=0", rsv_grant);
        end
        tick();
        idle();
        we = 2'b01; wa[0 +: AW] = 5'd7; wd[0 +: XLEN] = 32'hA5A5A5A5;
        tick();
        idle();
        ra[0 +: AW] = 5'd7;
        #1;
        total++;
        if (busy_vec[7] !== 1'b0 || rd[0 +: XLEN] !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL wb7 got busy=%b rd=%h exp busy=0 rd=a5a5a5a5", busy_vec[7], rd[0 +: XLEN]);
        end
    endtask

    task automatic test_write_while_busy();
        logic [XLEN-1:0] old_v;
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        old_v = m_rf[3];
        idle();
        we = 2'b01; wa[0 +: AW] = 5'd3; wd[0 +: XLEN] = 32'h1234; ra[0 +: AW] = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        total++;
        if (rd[0 +: XLEN] !== 32'h1234 || rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_x3 got rd=%h rbusy=%b exp 1234/0", rd[0 +: XLEN], rbusy[0]);
        end
`else
        total++;
        if (rd[0 +: XLEN] !== old_v || rbusy[0] !== 1'b1) begin
            bad++; $display("FAIL readold_x3 got rd=%h rbusy=%b exp %h/1", rd[0 +: XLEN], rbusy[0], old_v);
        end
`endif
        tick();
        idle();
        ra[0 +: AW] = 5'd3;
        #1;
        total++;
        if (rd[0 +: XLEN] !== 32'h1234 || rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL after_wb_x3 got rd=%h rbusy=%b exp 1234/0", rd[0 +: XLEN], rbusy[0]);
        end
    endtask

    task automatic test_rsv_and_write();
        idle();
        we = 2'b10; wa[AW +: AW] = 5'd9; wd[XLEN +: XLEN] = 32'hCAFEF00D;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        ra[AW +: AW] = 5'd9;
        #1;
        total++;
        if (rd[XLEN +: XLEN] !== 32'hCAFEF00D || busy_vec[9] !== 1'b1) begin
            bad++; $display("FAIL rsv_wr_x9 got rd=%h busy=%b exp cafef00d/1", rd[XLEN +: XLEN], busy_vec[9]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            we = NW'($urandom_range(0, 3));
            for (int w = 0; w < NW; w++) begin
                wa[w*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
                wd[w*XLEN +: XLEN] = $urandom;
            end
            for (int r = 0; r < NR; r++)
                ra[r*AW +: AW] = AW'(($urandom_range(0, 2) == 0) ? int'(wa[($urandom_range(0, 1))*AW +: AW])
                                                                : $urandom_range(0, 7));
            rsv_en = ($urandom_range(0, 1) == 1);
            rsv_addr = AW'($urandom_range(0, 7));
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                total++;
                if (rd[r*XLEN +: XLEN] !== exp_rd(int'(ra[r*AW +: AW]))) begin
                    bad++; $display("FAIL rand_rd n=%0d port=%0d got=%h exp=%h", n, r,
                                    rd[r*XLEN +: XLEN], exp_rd(int'(ra[r*AW +: AW])));
                end
                total++;
                if (rbusy[r] !== exp_busy(int'(ra[r*AW +: AW]))) begin
                    bad++; $display("FAIL rand_rbusy n=%0d port=%0d got=%b exp=%b", n, r,
                                    rbusy[r], exp_busy(int'(ra[r*AW +: AW])));
                end
            end
            total++;
            if (rsv_grant !== exp_grant()) begin
                bad++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, rsv_grant, exp_grant());
            end
            total++;
            if (busy_vec !== exp_vec()) begin
                bad++; $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, busy_vec, exp_vec());
            end
            tick();
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_rf[i] = '0;
            m_busy[i] = 1'b0;
        end
        idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        test_reset();
        test_same_addr_write();
        test_x0();
        test_reserve();
        test_write_while_busy();
        test_rsv_and_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
